// File: rtl/alu_pkg.sv
// Shared opcodes (ALU-control encodings) and FSM states for the execution-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier: WIDTH cycles from start, done is a combinational last-step flag.
// Product is the low WIDTH bits; abort drops the operation without touching the datapath.
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             abort,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count;
  logic             running;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  // product is valid during the final iteration so the caller can register it on that edge
  assign done     = running && (count == CW'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: 1-cycle ops, WIDTH-cycle MUL when ALU_MUL_EN is defined; result held
// in HOLD until out_ready, back-to-back accept allowed when out_ready is high.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  state_t           state;
  logic             accept;
  logic             slt;
  logic [WIDTH-1:0] alu_res;

  assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  // a flush cycle never accepts, even with in_valid and in_ready both high
  assign accept   = in_valid && in_ready && !flush;
  assign slt      = $signed(a) < $signed(b);

  always_comb begin
    alu_res = '0;
    case (operation)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR:  alu_res = ~(a | b);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic             busy_q;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign busy      = busy_q;
  assign mul_start = accept && (operation == OP_MUL);

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .abort   (flush),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
`ifdef ALU_MUL_EN
      busy_q    <= 1'b0;
`endif
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
`ifdef ALU_MUL_EN
      busy_q    <= 1'b0;
`endif
    end else begin
      case (state)
`ifdef ALU_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            result    <= mul_product;
            zero      <= (mul_product == '0);
            out_valid <= 1'b1;
            busy_q    <= 1'b0;
            state     <= ST_HOLD;
          end
        end
`endif
        default: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (operation == OP_MUL) begin
              state     <= ST_MUL;
              busy_q    <= 1'b1;
              out_valid <= 1'b0;
            end else
`endif
            begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end else if ((state == ST_HOLD) && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, handshake/flush/reset sequences, random ops vs model.
module tb_alu_exec_unit;

  localparam int W = 64;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   operation = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp_res;
    logic         exp_zero;
  } vec_t;

  vec_t       vecs[10];
  logic [3:0] ops[10];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference behaviour taken straight from the opcode table.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'b1100: return ~(x | y);
`ifdef ALU_MUL_EN
      4'b1000: return x * y;
`endif
      default: return '0;
    endcase
  endfunction

  task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int i;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    i = 0;
    while (!in_ready && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready actual=0 required=1");
    end
    in_valid  = 1'b1;
    operation = op;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic ez,
                        input int stall);
    int i;
    send(op, x, y);
    out_ready = (stall == 0);
    if (MUL_EN && op == 4'b1000) begin
      i = 0;
      while (!out_valid && i < 2 * W + 8) begin
        @(posedge clk);
        #1;
        i++;
      end
      chk({name, "_mul_lat"}, W'(i), W'(W));
    end else begin
      chk({name, "_valid"}, W'(out_valid), W'(1));
    end
    chk({name, "_res"}, result, er);
    chk({name, "_zero"}, W'(zero), W'(ez));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk({name, "_stall_res"}, result, er);
      chk({name, "_stall_valid"}, W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [3:0]   op;
    logic [W-1:0] er;
    int           n;
    int           bad;

    vecs[0] = '{4'b0010, W'(5),    W'(7),    W'(12),   1'b0};
    vecs[1] = '{4'b0110, W'(9),    W'(9),    W'(0),    1'b1};
    vecs[2] = '{4'b0110, W'(0),    W'(1),    ONES,     1'b0};
    vecs[3] = '{4'b0111, ONES,     W'(1),    W'(1),    1'b0};
    vecs[4] = '{4'b0111, W'(1),    ONES,     W'(0),    1'b1};
    vecs[5] = '{4'b0000, W'('hF0), W'('h3C), W'('h30), 1'b0};
    vecs[6] = '{4'b0001, W'(1),    W'(2),    W'(3),    1'b0};
    vecs[7] = '{4'b1100, W'(0),    W'(0),    ONES,     1'b0};
    vecs[8] = '{4'b0101, W'(3),    W'(4),    W'(0),    1'b1};
    vecs[9] = '{4'b0010, ONES,     W'(1),    W'(0),    1'b1};

    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
    ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b1000; ops[7] = 4'b0101;
    ops[8] = 4'b0011; ops[9] = 4'b1111;

    #12;
    chk("reset_valid", W'(out_valid), W'(0));
    chk("reset_result", result, W'(0));
    chk("reset_zero", W'(zero), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("idle_in_ready", W'(in_ready), W'(1));

    for (int v = 0; v < 10; v++)
      run_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].x, vecs[v].y,
             vecs[v].exp_res, vecs[v].exp_zero, 0);

    // Backpressure: ADD held for 3 cycles while a competing OR waits, then back-to-back.
    send(4'b0010, W'(10), W'(20));
    out_ready = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    operation = 4'b0001;
    a = W'(1);
    b = W'(2);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      chk("bp_result", result, W'(30));
      chk("bp_valid", W'(out_valid), W'(1));
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b_result", result, W'(3));
    chk("b2b_valid", W'(out_valid), W'(1));
    @(posedge clk);
    #1;
    chk("drain_valid", W'(out_valid), W'(0));
    chk("drain_in_ready", W'(in_ready), W'(1));

    // Flush while holding a result, with a request pending: no accept, result kept.
    send(4'b0010, W'(40), W'(2));
    out_ready = 1'b0;
    @(negedge clk);
    flush     = 1'b1;
    in_valid  = 1'b1;
    operation = 4'b0010;
    a = W'(100);
    b = W'(100);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", W'(out_valid), W'(0));
    chk("flush_result", result, W'(42));
    @(posedge clk);
    #1;
    chk("flush_no_accept", W'(out_valid), W'(0));

`ifdef ALU_MUL_EN
    send(4'b1000, W'(123), W'(456));
    out_ready = 1'b1;
    chk("mul_busy_start", W'(busy), W'(1));
    chk("mul_in_ready", W'(in_ready), W'(0));
    n = 0;
    bad = 0;
    while (!out_valid && n < 200) begin
      if (!busy || in_ready) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", W'(n), W'(W));
    chk("mul_busy_in_ready_viol", W'(bad), W'(0));
    chk("mul_busy_end", W'(busy), W'(0));
    chk("mul_result", result, W'(56088));
    run_op("mul_neg", 4'b1000, -W'(2), W'(3), -W'(6), 1'b0, 0);

    send(4'b1000, W'(77), W'(5));
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("mflush_valid", W'(out_valid), W'(0));
    chk("mflush_busy", W'(busy), W'(0));
    chk("mflush_in_ready", W'(in_ready), W'(1));
    chk("mflush_result", result, -W'(6));
    run_op("after_flush_add", 4'b0010, W'(1), W'(1), W'(2), 1'b0, 0);

    send(4'b1000, W'(9), W'(9));
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", W'(out_valid), W'(0));
    chk("mrst_result", result, W'(0));
    chk("mrst_zero", W'(zero), W'(0));
    chk("mrst_busy", W'(busy), W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run_op("after_rst_mul", 4'b1000, W'(7), W'(6), W'(42), 1'b0, 0);
`else
    run_op("mul_as_unknown", 4'b1000, W'(123), W'(456), W'(0), 1'b1, 0);
    chk("no_mul_busy", W'(busy), W'(0));
`endif

    for (int r = 0; r < 60; r++) begin
      op = ops[$urandom_range(0, 9)];
      x  = {$urandom, $urandom};
      y  = ($urandom_range(0, 3) == 0) ? x : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) x = W'($urandom_range(0, 15));
      er = ref_alu(op, x, y);
      run_op($sformatf("rnd%0d_op%0h", r, op), op, x, y, er, (er == '0),
             $urandom_range(0, 2));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
